countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per 1 s count tick.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles per blink half-period.
REQ-003 SHALL have port clk, input, 1, the single clock (100 MHz), rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, single-cycle pulse that loads the preset value.
REQ-006 SHALL have port start_stop, input, 1, single-cycle pulse that toggles run/pause (debounced upstream).
REQ-007 SHALL have port preset_m1, preset_m0, preset_s1, preset_s0, input, 4 each, BCD preset MM:SS.
REQ-008 SHALL have port digit3, digit2, digit1, digit0, output, 4 each, BCD M tens, M ones, S tens, S ones, registered.
REQ-009 SHALL have port blink, output, 1, display blank request, registered.
REQ-010 SHALL have ports running and expired, output, 1 each, state flags, registered.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, PAUSE, EXPIRED.
REQ-012 On load, from any state, SHALL copy the preset into the digits and enter IDLE on the next edge. Preset digits above 9 saturate to 9. preset_s1 above 5 saturates to 5.
REQ-013 start_stop SHALL move IDLE->RUN if digits are not 00:00, else be ignored. It SHALL move RUN->PAUSE, PAUSE->RUN, and EXPIRED->IDLE with digits held at 00:00.
REQ-014 When load and start_stop are both asserted in the same cycle, load SHALL win and start_stop SHALL be dropped.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and clear on load and on IDLE->RUN.
REQ-016 A tick SHALL occur in the cycle the prescaler equals TICK_DIV-1 and SHALL decrement MM:SS by one second on the same edge.
REQ-017 The decrement SHALL borrow as follows: s0 0->9 borrows from s1; s1 0->5 borrows from m0; m0 0->9 borrows from m1. Example: 10:00 -> 09:59.
REQ-018 A tick at 00:01 SHALL produce 00:00 and enter EXPIRED on the same edge. The counter SHALL never wrap below 00:00.
REQ-019 A start_stop in the same cycle as a RUN tick SHALL apply the tick first, then pause. If that tick reaches 00:00, EXPIRED SHALL win.
REQ-020 running SHALL be 1 only in RUN. expired SHALL be 1 only in EXPIRED.
REQ-021 blink SHALL be 0 outside EXPIRED.
REQ-022 Latency from an input pulse to the updated outputs SHALL be exactly one clk edge.

Reset
REQ-023 While rst_n is 0, the block SHALL asynchronously force state IDLE, all digits 0, blink 0, running 0, expired 0, and the prescaler and blink counter 0.
REQ-024 Reset deassertion in the middle of a count SHALL resume in IDLE at 00:00. No partial tick SHALL be retained.

Configuration
REQ-025 Macro COUNTDOWN_BLINK_EN SHALL control the expiry blink.
- Defined: in EXPIRED, blink is 1 on entry and toggles every BLINK_DIV cycles, via a blink counter cleared on entry.
- Undefined: blink is constant 0 and no blink counter is synthesized.

Structure
REQ-026 Shared package timer_pkg SHALL hold the FSM state typedef and the constants BCD_W=4, SEC_TENS_MAX=5 and DIGIT_MAX=9.
REQ-027 A sub-module bcd_digit_dec SHALL be used, instantiated four times. It takes digit, wrap value and decrement enable, and outputs next digit and borrow.
REQ-028 The prescaler, FSM and blink counter SHALL reside in countdown_timer.

Verification (TICK_DIV=4, BLINK_DIV=3)
REQ-029 Scenario: preset 00:02, load, start_stop -> running=1, then 00:01 after 4 cycles and 00:00 after 8 cycles; expired=1 and running=0 on that edge.
REQ-030 Scenario: preset 10:00, run one tick -> digits 0,9,5,9. Then preset 00:00 and start_stop -> state stays IDLE, running=0.
REQ-031 Scenario: pause after 2 prescaler cycles, wait 20 cycles, resume -> next tick 2 cycles after resume and digits unchanged during the pause.
REQ-032 Scenario: load and start_stop in the same cycle with preset 05:30 -> IDLE, digits 0,5,3,0, running=0.
REQ-033 Scenario: with COUNTDOWN_BLINK_EN, enter EXPIRED -> blink sequence 1,1,1,0,0,0,1... Then start_stop -> IDLE, blink=0, digits 00:00.
REQ-034 Scenario: drop rst_n mid-RUN at 07:43, away from any clk edge -> outputs zero immediately, and IDLE after release.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the countdown_timer block.
//
// Holds the FSM state type, the BCD digit width and the saturation/wrap
// limits used by the MM:SS counter, plus a small saturation helper used
// when a preset is loaded.
package timer_pkg;

    localparam int BCD_W = 4;

    // Largest legal value of a seconds-tens digit and of any other digit.
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Clamp a preset digit to the largest value that digit position can hold.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d,
                                                 input logic [BCD_W-1:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if -- bundles the control and display signals of the
// countdown_timer so a controller and a display/monitor can share one handle.
//
// Signals:
//   load, start_stop          control pulses towards the timer
//   preset_m1..preset_s0      BCD preset MM:SS towards the timer
//   digit3..digit0            BCD MM:SS shown by the timer
//   blink, running, expired   status flags from the timer
//
// Modports:
//   master -- drives control and preset, observes display/status
//   slave  -- the timer side
interface countdown_timer_if;
    import timer_pkg::*;

    logic             load;
    logic             start_stop;
    logic [BCD_W-1:0] preset_m1;
    logic [BCD_W-1:0] preset_m0;
    logic [BCD_W-1:0] preset_s1;
    logic [BCD_W-1:0] preset_s0;
    logic [BCD_W-1:0] digit3;
    logic [BCD_W-1:0] digit2;
    logic [BCD_W-1:0] digit1;
    logic [BCD_W-1:0] digit0;
    logic             blink;
    logic             running;
    logic             expired;

    modport master (
        output load, start_stop, preset_m1, preset_m0, preset_s1, preset_s0,
        input  digit3, digit2, digit1, digit0, blink, running, expired
    );

    modport slave (
        input  load, start_stop, preset_m1, preset_m0, preset_s1, preset_s0,
        output digit3, digit2, digit1, digit0, blink, running, expired
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec -- one BCD digit of a down-counter.
//
// Ports:
//   digit       current digit value
//   wrap_val    value the digit takes when it decrements from 0
//   dec_en      decrement request (the borrow from the digit below)
//   next_digit  digit value after the optional decrement
//   borrow      1 when the digit wrapped and the digit above must decrement
module bcd_digit_dec
    import timer_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic [BCD_W-1:0] wrap_val,
    input  logic             dec_en,
    output logic [BCD_W-1:0] next_digit,
    output logic             borrow
);

    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_digit = digit;
        borrow     = 1'b0;
        if (dec_en) begin
            if (digit == '0) begin
                next_digit = wrap_val;
                borrow     = 1'b1;
            end else begin
                next_digit = digit - BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer -- MM:SS countdown timer with load, run/pause and expiry.
//
// Parameters:
//   TICK_DIV   clk cycles per one-second count tick
//   BLINK_DIV  clk cycles per blink half-period in the expired state
//
// Ports:
//   clk, rst_n                clock (rising edge), asynchronous active-low reset
//   load                      pulse: copy the saturated preset, go IDLE
//   start_stop                pulse: IDLE->RUN, RUN<->PAUSE, EXPIRED->IDLE
//   preset_m1..preset_s0      BCD preset MM:SS
//   digit3..digit0            registered BCD MM:SS (M tens, M ones, S tens, S ones)
//   blink                     registered display blank request
//   running, expired          registered state flags
//
// Build option:
//   COUNTDOWN_BLINK_EN  when defined, blink toggles every BLINK_DIV cycles in
//                       the expired state starting at 1; otherwise blink is 0
//                       and no blink counter exists.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 100000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             start_stop,
    input  logic [BCD_W-1:0] preset_m1,
    input  logic [BCD_W-1:0] preset_m0,
    input  logic [BCD_W-1:0] preset_s1,
    input  logic [BCD_W-1:0] preset_s0,
    output logic [BCD_W-1:0] digit3,
    output logic [BCD_W-1:0] digit2,
    output logic [BCD_W-1:0] digit1,
    output logic [BCD_W-1:0] digit0,
    output logic             blink,
    output logic             running,
    output logic             expired
);

    localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BCD_W-1:0]   m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
    logic               running_q, running_d;
    logic               expired_q, expired_d;

    logic               tick;
    logic               digits_zero;
    logic               dec_zero;
    logic [BCD_W-1:0]   m1_dec, m0_dec, s1_dec, s0_dec;
    logic               s0_borrow, s1_borrow, m0_borrow, m1_borrow;

    // ---------------------------------------------------------------
    // Decrement chain: each digit decrements when the one below wraps.
    // ---------------------------------------------------------------
    assign tick = (state_q == ST_RUN) && (presc_q == TICK_LAST);

    bcd_digit_dec u_dec_s0 (
        .digit      (s0_q),
        .wrap_val   (DIGIT_MAX),
        .dec_en     (tick),
        .next_digit (s0_dec),
        .borrow     (s0_borrow)
    );

    bcd_digit_dec u_dec_s1 (
        .digit      (s1_q),
        .wrap_val   (SEC_TENS_MAX),
        .dec_en     (s0_borrow),
        .next_digit (s1_dec),
        .borrow     (s1_borrow)
    );

    bcd_digit_dec u_dec_m0 (
        .digit      (m0_q),
        .wrap_val   (DIGIT_MAX),
        .dec_en     (s1_borrow),
        .next_digit (m0_dec),
        .borrow     (m0_borrow)
    );

    bcd_digit_dec u_dec_m1 (
        .digit      (m1_q),
        .wrap_val   (DIGIT_MAX),
        .dec_en     (m0_borrow),
        .next_digit (m1_dec),
        .borrow     (m1_borrow)
    );

    assign digits_zero = (m1_q == '0) && (m0_q == '0) && (s1_q == '0) && (s0_q == '0);
    assign dec_zero    = (m1_dec == '0) && (m0_dec == '0) && (s1_dec == '0) && (s0_dec == '0);

    // ---------------------------------------------------------------
    // FSM, prescaler and digit next-state.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        s1_d    = s1_q;
        s0_d    = s0_q;

        if (load) begin
            // load overrides everything, including a simultaneous start_stop.
            state_d = ST_IDLE;
            presc_d = '0;
            m1_d    = bcd_sat(preset_m1, DIGIT_MAX);
            m0_d    = bcd_sat(preset_m0, DIGIT_MAX);
            s1_d    = bcd_sat(preset_s1, SEC_TENS_MAX);
            s0_d    = bcd_sat(preset_s0, DIGIT_MAX);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_stop && !digits_zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end

                ST_RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        // A borrow out of the minutes tens would mean wrapping
                        // below 00:00; refuse it and just expire.
                        if (!m1_borrow) begin
                            m1_d = m1_dec;
                            m0_d = m0_dec;
                            s1_d = s1_dec;
                            s0_d = s0_dec;
                        end
                        // Expiry outranks a pause requested on the same edge.
                        if (dec_zero || m1_borrow) begin
                            state_d = ST_EXPIRED;
                        end else if (start_stop) begin
                            state_d = ST_PAUSE;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                        if (start_stop) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end

                ST_PAUSE: begin
                    // Prescaler holds so the partial second resumes intact.
                    if (start_stop) begin
                        state_d = ST_RUN;
                    end
                end

                ST_EXPIRED: begin
                    if (start_stop) begin
                        state_d = ST_IDLE;
                        m1_d    = '0;
                        m0_d    = '0;
                        s1_d    = '0;
                        s0_d    = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they change on the same
    // edge as the state itself.
    assign running_d = (state_d == ST_RUN);
    assign expired_d = (state_d == ST_EXPIRED);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            m1_q      <= '0;
            m0_q      <= '0;
            s1_q      <= '0;
            s0_q      <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            m1_q      <= m1_d;
            m0_q      <= m0_d;
            s1_q      <= s1_d;
            s0_q      <= s0_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign digit3  = m1_q;
    assign digit2  = m0_q;
    assign digit1  = s1_q;
    assign digit0  = s0_q;
    assign running = running_q;
    assign expired = expired_q;

    // ---------------------------------------------------------------
    // Expiry blink.
    // ---------------------------------------------------------------
`ifdef COUNTDOWN_BLINK_EN
    localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == ST_EXPIRED) begin
            if (state_q != ST_EXPIRED) begin
                // Entry: display on, fresh half-period.
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = !blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer -- self-checking bench for countdown_timer with
// TICK_DIV=4, BLINK_DIV=3. A table of single-cycle vectors, hand-written
// multi-cycle sequences and a randomized run are compared against a
// seconds-based reference model kept here.
module tb_countdown_timer;

    localparam int TB_TICK  = 4;
    localparam int TB_BLINK = 3;
`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    localparam int MD_IDLE = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_EXP  = 3;

    logic clk;
    logic rst_n;

    countdown_timer_if tif ();

    countdown_timer #(
        .TICK_DIV  (TB_TICK),
        .BLINK_DIV (TB_BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tif.load),
        .start_stop (tif.start_stop),
        .preset_m1  (tif.preset_m1),
        .preset_m0  (tif.preset_m0),
        .preset_s1  (tif.preset_s1),
        .preset_s0  (tif.preset_s0),
        .digit3     (tif.digit3),
        .digit2     (tif.digit2),
        .digit1     (tif.digit1),
        .digit0     (tif.digit0),
        .blink      (tif.blink),
        .running    (tif.running),
        .expired    (tif.expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (whole seconds + phase) ----------------
    int m_mode;
    int m_secs;
    int m_phase;
    int m_expc;

    function automatic int sat(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_secs  = 0;
        m_phase = 0;
        m_expc  = 0;
    endtask

    task automatic model_step(input logic ld, input logic ss, input logic [15:0] pre);
        bit t;
        if (ld) begin
            m_mode  = MD_IDLE;
            m_phase = 0;
            m_secs  = sat(int'(pre[15:12]), 9) * 600 + sat(int'(pre[11:8]), 9) * 60
                    + sat(int'(pre[7:4]), 5) * 10 + sat(int'(pre[3:0]), 9);
        end else begin
            case (m_mode)
                MD_IDLE: if (ss && m_secs != 0) begin
                    m_mode  = MD_RUN;
                    m_phase = 0;
                end
                MD_RUN: begin
                    t       = (m_phase == TB_TICK - 1);
                    m_phase = (m_phase + 1) % TB_TICK;
                    if (t) m_secs = m_secs - 1;
                    if (t && m_secs == 0) begin
                        m_mode = MD_EXP;
                        m_expc = 0;
                    end else if (ss) begin
                        m_mode = MD_PAUSE;
                    end
                end
                MD_PAUSE: if (ss) m_mode = MD_RUN;
                default: begin
                    if (ss) m_mode = MD_IDLE;
                    else    m_expc = m_expc + 1;
                end
            endcase
        end
    endtask

    function automatic logic [15:0] model_digits();
        int mm;
        int ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic model_blink();
        return BLINK_EN && (m_mode == MD_EXP) && (((m_expc / TB_BLINK) % 2) == 0);
    endfunction

    function automatic logic [15:0] dut_digits();
        return {tif.digit3, tif.digit2, tif.digit1, tif.digit0};
    endfunction

    task automatic compare_model();
        check("model_digits",  32'(dut_digits()), 32'(model_digits()));
        check("model_running", 32'(tif.running),  32'(m_mode == MD_RUN));
        check("model_expired", 32'(tif.expired),  32'(m_mode == MD_EXP));
        check("model_blink",   32'(tif.blink),    32'(model_blink()));
    endtask

    // One clock cycle: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input logic ld, input logic ss, input logic [15:0] pre);
        tif.load       = ld;
        tif.start_stop = ss;
        {tif.preset_m1, tif.preset_m0, tif.preset_s1, tif.preset_s0} = pre;
        model_step(ld, ss, pre);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        ld;
        logic        ss;
        logic [15:0] pre;
        logic [15:0] exp_dig;
        logic        exp_run;
        logic        exp_exp;
    } vec_t;

    vec_t vecs[13];
    logic blink_seq[7];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'hFFFF, 16'h9959, 1'b0, 1'b0}; // saturation
        vecs[1]  = '{1'b1, 1'b1, 16'h0530, 16'h0530, 1'b0, 1'b0}; // load beats start
        vecs[2]  = '{1'b0, 1'b1, 16'h1234, 16'h0530, 1'b1, 1'b0}; // start
        vecs[3]  = '{1'b0, 1'b1, 16'h1234, 16'h0530, 1'b0, 1'b0}; // pause
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0}; // load from pause
        vecs[5]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0}; // start at 00:00 ignored
        vecs[6]  = '{1'b1, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 16'h1000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0959, 1'b1, 1'b0}; // borrow chain
        vecs[12] = '{1'b1, 1'b0, 16'h1A7C, 16'h1959, 1'b0, 1'b0}; // per-digit saturation
        blink_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        tif.load = 1'b0;
        tif.start_stop = 1'b0;
        {tif.preset_m1, tif.preset_m0, tif.preset_s1, tif.preset_s0} = 16'h0000;
        model_reset();

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits",  32'(dut_digits()), 32'h0);
        check("reset_running", 32'(tif.running),  32'h0);
        check("reset_expired", 32'(tif.expired),  32'h0);
        check("reset_blink",   32'(tif.blink),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].ld, vecs[i].ss, vecs[i].pre);
            check($sformatf("vec%0d_digits", i),  32'(dut_digits()), 32'(vecs[i].exp_dig));
            check($sformatf("vec%0d_running", i), 32'(tif.running),  32'(vecs[i].exp_run));
            check($sformatf("vec%0d_expired", i), 32'(tif.expired),  32'(vecs[i].exp_exp));
        end

        // ---- 00:02 runs down to expiry ----
        step(1'b1, 1'b0, 16'h0002);
        step(1'b0, 1'b1, 16'h0000);
        check("run2_running", 32'(tif.running), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000);
        check("run2_one_sec", 32'(dut_digits()), 32'h0001);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000);
        check("run2_zero",    32'(dut_digits()), 32'h0000);
        check("run2_expired", 32'(tif.expired),  32'h1);
        check("run2_stopped", 32'(tif.running),  32'h0);

        // ---- blink sequence while expired, then start_stop back to IDLE ----
        check("blink_entry", 32'(tif.blink), 32'(BLINK_EN & blink_seq[0]));
        for (int i = 1; i < 7; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            check($sformatf("blink_seq%0d", i), 32'(tif.blink), 32'(BLINK_EN & blink_seq[i]));
        end
        step(1'b0, 1'b1, 16'h0000);
        check("exp_clear_blink",   32'(tif.blink),    32'h0);
        check("exp_clear_expired", 32'(tif.expired),  32'h0);
        check("exp_clear_digits",  32'(dut_digits()), 32'h0000);

        // ---- pause after two prescaler cycles, hold, resume ----
        step(1'b1, 1'b0, 16'h0130);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        check("pause_running", 32'(tif.running), 32'h0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            check("pause_hold", 32'(dut_digits()), 32'h0130);
        end
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        check("resume_pre_tick", 32'(dut_digits()), 32'h0130);
        step(1'b0, 1'b0, 16'h0000);
        check("resume_tick",     32'(dut_digits()), 32'h0129);

        // ---- start_stop on the tick edge: tick applies, then pause ----
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        check("tick_pause_digits",  32'(dut_digits()), 32'h0128);
        check("tick_pause_running", 32'(tif.running),  32'h0);

        // ---- asynchronous reset mid-run at 07:43 ----
        step(1'b1, 1'b0, 16'h0744);
        step(1'b0, 1'b1, 16'h0000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000);
        check("prereset_digits", 32'(dut_digits()), 32'h0743);
        tif.load = 1'b0;
        tif.start_stop = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_digits",  32'(dut_digits()), 32'h0);
        check("async_rst_running", 32'(tif.running),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 16'h0000);
        check("post_rst_digits",  32'(dut_digits()), 32'h0);
        step(1'b0, 1'b1, 16'h0000);
        check("post_rst_running", 32'(tif.running),  32'h0);

        // ---- randomized run against the model ----
        for (int i = 0; i < 600; i++) begin
            logic        ld;
            logic        ss;
            logic [15:0] pre;
            ld = ($urandom_range(0, 19) == 0);
            ss = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0) pre = 16'($urandom());
            else                          pre = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            step(ld, ss, pre);
        end

        tif.load = 1'b0;
        tif.start_stop = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
